// File: rtl/pipe_flush_reg.sv
// Single pipeline stage with a channel-select mux, stall hold and a
// flush sequencer that inserts a fixed number of bubble cycles.
module pipe_flush_reg #(
  parameter int unsigned     bits      = 32,
  parameter int unsigned     channels  = 4,
  parameter int unsigned     flush_len = 2,
  parameter logic [bits-1:0] nop_value = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [channels*bits-1:0]     data_in,
  input  logic [$clog2(channels)-1:0]  selector,
  input  logic                         valid_in,
  input  logic                         stall,
  input  logic                         flush,
  output logic [bits-1:0]              Q,
  output logic                         valid_out,
  output logic                         flushing
);

  localparam int unsigned sel_w = $clog2(channels);
  localparam int unsigned cnt_w = $clog2(flush_len + 1);

  // Counter value loaded on a flush edge; the flush edge itself is the first bubble.
  localparam logic [cnt_w-1:0] cnt_reload = cnt_w'(flush_len - 1);
  localparam logic [cnt_w-1:0] cnt_one    = cnt_w'(1);
  // A single-bubble flush never needs the FLUSH state.
  localparam bit multi_bubble = (flush_len > 1);

  typedef enum logic {StRun, StFlush} state_e;

  state_e          state_q;
  logic [cnt_w-1:0] cnt_q;
  logic [bits-1:0]  q_q;
  logic             valid_q;
  logic [bits-1:0]  sel_data;

  // Channel mux; selector values with no matching channel fall back to channel 0.
  always_comb begin
    sel_data = data_in[0 +: bits];
    for (int k = 1; k < channels; k++) begin
      if (selector == sel_w'(k)) begin
        sel_data = data_in[k*bits +: bits];
      end
    end
  end

  // Stage register and flush sequencer; flush outranks stall in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      q_q     <= nop_value;
      valid_q <= 1'b0;
    end else if (flush) begin
      q_q     <= nop_value;
      valid_q <= 1'b0;
      cnt_q   <= cnt_reload;
      state_q <= multi_bubble ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!stall) begin
            q_q     <= sel_data;
            valid_q <= valid_in;
          end
        end
        StFlush: begin
          // Bubbles keep coming regardless of stall; inputs are ignored.
          q_q     <= nop_value;
          valid_q <= 1'b0;
          if (cnt_q <= cnt_one) begin
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q - cnt_one;
          end
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Q         = q_q;
  assign valid_out = valid_q;
  assign flushing  = (state_q == StFlush);

endmodule

// File: tb/tb_pipe_flush_reg.sv
// Directed bench for pipe_flush_reg: two instances (4ch/flush 2/nop 0 and
// 3ch/flush 3/nop 0x13), expected stage contents queued per driven cycle.
module tb_pipe_flush_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: bits 32, channels 4, flush_len 2, nop 0
  logic              rst_a;
  logic [4*32-1:0]   data_a;
  logic [1:0]        sel_a;
  logic              vin_a, stall_a, flush_a;
  logic [31:0]       q_a;
  logic              vout_a, fl_a;

  // Instance B: bits 32, channels 3, flush_len 3, nop 0x13
  logic              rst_b;
  logic [3*32-1:0]   data_b;
  logic [1:0]        sel_b;
  logic              vin_b, stall_b, flush_b;
  logic [31:0]       q_b;
  logic              vout_b, fl_b;

  pipe_flush_reg #(
    .bits(32), .channels(4), .flush_len(2), .nop_value(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .data_in(data_a), .selector(sel_a), .valid_in(vin_a),
    .stall(stall_a), .flush(flush_a), .Q(q_a), .valid_out(vout_a), .flushing(fl_a)
  );

  pipe_flush_reg #(
    .bits(32), .channels(3), .flush_len(3), .nop_value(32'h0000_0013)
  ) dut_b (
    .clk(clk), .rst(rst_b), .data_in(data_b), .selector(sel_b), .valid_in(vin_b),
    .stall(stall_b), .flush(flush_b), .Q(q_b), .valid_out(vout_b), .flushing(fl_b)
  );

  // {q, valid_out, flushing}
  logic [33:0] sb_a[$];
  logic [33:0] sb_b[$];
  int checks   = 0;
  int failures = 0;

  task automatic compare(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed q=%h valid=%b flushing=%b expected q=%h valid=%b flushing=%b",
             tag, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic pop_a(input string tag);
    logic [33:0] e;
    e = sb_a.pop_front();
    compare(tag, {q_a, vout_a, fl_a}, e);
  endtask

  task automatic pop_b(input string tag);
    logic [33:0] e;
    e = sb_b.pop_front();
    compare(tag, {q_b, vout_b, fl_b}, e);
  endtask

  task automatic cyc_a(input logic [1:0] sel, input logic vin, input logic st, input logic fl,
                       input logic [31:0] eq, input logic ev, input logic ef, input string tag);
    sel_a = sel; vin_a = vin; stall_a = st; flush_a = fl;
    sb_a.push_back({eq, ev, ef});
    @(posedge clk);
    #1;
    pop_a(tag);
  endtask

  task automatic cyc_b(input logic [1:0] sel, input logic vin, input logic st, input logic fl,
                       input logic [31:0] eq, input logic ev, input logic ef, input string tag);
    sel_b = sel; vin_b = vin; stall_b = st; flush_b = fl;
    sb_b.push_back({eq, ev, ef});
    @(posedge clk);
    #1;
    pop_b(tag);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sel_a = '0; vin_a = 1'b0; stall_a = 1'b0; flush_a = 1'b0;
    sel_b = '0; vin_b = 1'b0; stall_b = 1'b0; flush_b = 1'b0;
    data_a = '0;
    data_a[0*32 +: 32] = 32'hCAFE_0000;
    data_a[1*32 +: 32] = 32'h0000_0013;
    data_a[2*32 +: 32] = 32'hDEAD_BEEF;
    data_a[3*32 +: 32] = 32'h3333_3333;
    data_b = '0;
    data_b[0*32 +: 32] = 32'h0BAD_F00D;
    data_b[1*32 +: 32] = 32'hB1B1_B1B1;
    data_b[2*32 +: 32] = 32'hC2C2_C2C2;

    // ---- Instance A ----
    #1;
    sb_a.push_back({32'h0, 1'b0, 1'b0});
    pop_a("reset_a");
    // Edge with reset held must not load anything
    sel_a = 2'd2; vin_a = 1'b1; flush_a = 1'b0;
    sb_a.push_back({32'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    pop_a("rst_edge_a");
    #2 rst_a = 1'b0;

    cyc_a(2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, "pass_ch2");
    cyc_a(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b1, 1'b0, "load_13");
    data_a[1*32 +: 32] = 32'h1111_1111;
    cyc_a(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, "stall_1");
    cyc_a(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, "stall_2");
    cyc_a(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, "stall_3");
    cyc_a(2'd1, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 1'b0, "stall_release");
    cyc_a(2'd2, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, "flush_edge");
    cyc_a(2'd2, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, "flush_bubble2");
    cyc_a(2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, "flush_resume");
    cyc_a(2'd3, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, "stall_flush");
    cyc_a(2'd3, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, "stall_flush_b2");
    cyc_a(2'd3, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, "stall_after_flush");
    cyc_a(2'd3, 1'b1, 1'b0, 1'b0, 32'h3333_3333, 1'b1, 1'b0, "sel3_a");
    cyc_a(2'd0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000, 1'b0, 1'b0, "sel0_invalid");
    cyc_a(2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, "pre_rst_a");
    // Async reset between edges
    rst_a = 1'b1;
    #2;
    sb_a.push_back({32'h0, 1'b0, 1'b0});
    pop_a("async_rst_a");
    @(negedge clk);
    rst_a = 1'b0;
    cyc_a(2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, "post_rst_a");

    // ---- Instance B ----
    sb_b.push_back({32'h0000_0013, 1'b0, 1'b0});
    pop_b("reset_b");
    @(negedge clk);
    rst_b = 1'b0;
    cyc_b(2'd3, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, "sel_oor");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b0, 32'hC2C2_C2C2, 1'b1, 1'b0, "sel2_b");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, "reflush_e0");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b1, "reflush_b1");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, "reflush_e2");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b1, "reflush_b3");
    cyc_b(2'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b0, "reflush_b4");
    cyc_b(2'd1, 1'b1, 1'b0, 1'b0, 32'hB1B1_B1B1, 1'b1, 1'b0, "reflush_resume");
    cyc_b(2'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, "fstall_e0");
    cyc_b(2'd1, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b1, "fstall_b1");
    cyc_b(2'd1, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0, "fstall_b2");
    cyc_b(2'd1, 1'b1, 1'b0, 1'b0, 32'hB1B1_B1B1, 1'b1, 1'b0, "fstall_resume");
    cyc_b(2'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, "mid_e0");
    // Async reset in the middle of the bubble sequence
    rst_b = 1'b1;
    #2;
    sb_b.push_back({32'h0000_0013, 1'b0, 1'b0});
    pop_b("async_rst_midflush");
    @(negedge clk);
    rst_b = 1'b0;
    cyc_b(2'd3, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, "post_rst_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
